voice_alloc: RTL and testbench
==============================

VOICE_ALLOC -- requirements
Module: voice_alloc

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low.
REQ-002 SHALL have parameter AGE_W, default 6, meaning the width of each per-voice age counter.
REQ-003 SHALL have ports, one per line:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- note_num  in  7  MIDI note number
- note_vel  in  7  MIDI velocity
- note_on  in  1  one-cycle strobe
- note_off  in  1  one-cycle strobe
- all_off  in  1  one-cycle strobe, from CC 123
- env_idle  in  4  per-voice ADSR envelope at zero, level
- voice_note  out  28  voice v note at [7v+6:7v]
- voice_vel  out  28  voice v velocity at [7v+6:7v]
- gate_on  out  4  one-cycle trigger per voice
- gate_off  out  4  one-cycle release per voice
- voice_busy  out  4  voice state is not FREE
- steal  out  1  one-cycle pulse; a busy voice was reassigned
- drop  out  1  one-cycle pulse; a note_on was discarded

Function
REQ-004 Each of the 4 voices SHALL hold a state FREE, HELD or RELEASING, plus note, velocity and age registers.
REQ-005 All outputs SHALL be registered; the response SHALL appear on the cycle after the input strobe (latency 1).
REQ-006 note_on with note_vel=0 SHALL be treated as note_off.
REQ-007 Retrigger: on note_on whose note matches a HELD or RELEASING voice, that voice SHALL take the new velocity, go to HELD, reset its age to 0 and pulse gate_on; steal SHALL NOT pulse.
REQ-008 When no voice matches, note_on SHALL select the lowest-index FREE voice.
REQ-009 Selection at REQ-008 SHALL load note and velocity, go to HELD, reset age to 0 and pulse gate_on.
REQ-010 On allocation, every other busy voice SHALL increment its age, saturating at 2^AGE_W-1.
REQ-011 Among equal ages, the lowest index SHALL be treated as oldest.
REQ-012 note_off SHALL move every HELD voice with a matching note to RELEASING and pulse its gate_off.
REQ-013 note_off with no matching HELD voice SHALL be ignored, with no output pulse.
REQ-014 A RELEASING voice SHALL go to FREE on a cycle with its env_idle bit high.
REQ-015 env_idle SHALL be ignored in the FREE and HELD states.
REQ-016 all_off SHALL move every HELD voice to RELEASING with gate_off pulses.
REQ-017 all_off SHALL take priority; note_on and note_off in the same cycle SHALL be discarded, with no drop pulse.
REQ-018 When note_on and note_off coincide, note_on SHALL be processed and note_off SHALL be discarded.
REQ-019 gate_on and gate_off SHALL never both be high for the same voice.
REQ-020 voice_note and voice_vel SHALL hold their last value after a voice becomes FREE.

Reset
REQ-021 rst low SHALL set, asynchronously, all voices to FREE and all note, velocity and age registers to 0.
REQ-022 rst low SHALL drive all outputs to 0.
REQ-023 A strobe coincident with reset deassertion SHALL be ignored.
REQ-024 Reset during a held note SHALL discard the note; the next note_on after reset SHALL allocate voice 0.

Configuration
REQ-025 Macro VOICE_STEAL_EN SHALL select the stealing behaviour.
REQ-026 Defined: with no FREE voice, note_on SHALL take the oldest RELEASING voice, else the oldest HELD voice, load it per REQ-009 and pulse steal; drop SHALL never assert.
REQ-027 Undefined: with no FREE voice, note_on SHALL be discarded and drop SHALL pulse; steal SHALL be constant 0.

Verification
REQ-028 Bench SHALL cover: reset, then note_on 60/100 -> next cycle voice 0 HELD, voice_note[6:0]=60, gate_on=0001, voice_busy=0001.
REQ-029 Bench SHALL cover: notes 60,62,64,65 then note_off 62 -> gate_off=0010; env_idle[1]=1 -> voice_busy=1101; note_on 67 -> voice 1.
REQ-030 Bench SHALL cover: note_on 60/100, then note_on 60/50 -> voice 0 retriggered, velocity 50, gate_on=0001, steal=0, no second voice used.
REQ-031 Bench SHALL cover: four voices held, with voice 2 RELEASING, then note_on 70 -> with VOICE_STEAL_EN voice 2 gets 70 and steal=1; without it drop=1 and voices unchanged.
REQ-032 Bench SHALL cover: all_off and note_on 72 in the same cycle -> all HELD voices get gate_off, the note is discarded, drop=0.
REQ-033 Bench SHALL cover: 70 allocations with 3 voices held -> ages saturate at 63 without wrap; the oldest voice is chosen per REQ-011.

Source files
------------

// File: rtl/voice_alloc.sv
`default_nettype none
// ============================================================================
// Module      : voice_alloc
// Description : Four-voice polyphonic note allocator with retrigger, aging and
//               release tracking. Macro VOICE_STEAL_EN enables voice stealing.
// Revision    : 1.0 - initial release
// ============================================================================
module voice_alloc #(
    parameter int AGE_W = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  note_num,
    input  logic [6:0]  note_vel,
    input  logic        note_on,
    input  logic        note_off,
    input  logic        all_off,
    input  logic [3:0]  env_idle,
    output logic [27:0] voice_note,
    output logic [27:0] voice_vel,
    output logic [3:0]  gate_on,
    output logic [3:0]  gate_off,
    output logic [3:0]  voice_busy,
    output logic        steal,
    output logic        drop
);

    localparam int         c_NV   = 4;
    localparam logic [1:0] c_FREE = 2'd0;
    localparam logic [1:0] c_HELD = 2'd1;
    localparam logic [1:0] c_REL  = 2'd2;

    logic [1:0]       r_state [c_NV];
    logic [6:0]       r_note  [c_NV];
    logic [6:0]       r_vel   [c_NV];
    logic [AGE_W-1:0] r_age   [c_NV];
    logic [3:0]       r_gate_on, r_gate_off, r_busy;
    logic             r_steal, r_drop;
    // Blocks strobes on the first edge after reset release.
    logic             r_run;

    logic             w_all, w_on, w_off;
    logic             w_hit, w_free_any, w_load, w_alloc, w_steal, w_drop;
    logic [1:0]       w_hit_idx, w_free_idx, w_sel;
    logic [1:0]       w_nstate [c_NV];
    logic [AGE_W-1:0] w_nage   [c_NV];
    logic [c_NV-1:0]  w_ld, w_gon, w_goff, w_busy;
`ifdef VOICE_STEAL_EN
    logic             w_rel_any, w_held_any;
    logic [1:0]       w_rel_idx, w_held_idx;
    logic [AGE_W-1:0] w_rel_age, w_held_age;
`endif

    always_comb begin
        w_all      = r_run && all_off;
        w_on       = r_run && !all_off && note_on && (note_vel != 7'd0);
        w_off      = r_run && !all_off && !w_on && (note_on || note_off);
        w_hit      = 1'b0;
        w_hit_idx  = '0;
        w_free_any = 1'b0;
        w_free_idx = '0;
        // Descending scan so the lowest index wins.
        for (int v = c_NV - 1; v >= 0; v--) begin
            if (r_state[v] != c_FREE && r_note[v] == note_num) begin
                w_hit     = 1'b1;
                w_hit_idx = 2'(v);
            end
            if (r_state[v] == c_FREE) begin
                w_free_any = 1'b1;
                w_free_idx = 2'(v);
            end
        end
`ifdef VOICE_STEAL_EN
        w_rel_any  = 1'b0;
        w_rel_idx  = '0;
        w_rel_age  = '0;
        w_held_any = 1'b0;
        w_held_idx = '0;
        w_held_age = '0;
        // Strictly-greater compare keeps the lowest index on equal ages.
        for (int v = 0; v < c_NV; v++) begin
            if (r_state[v] == c_REL && (!w_rel_any || r_age[v] > w_rel_age)) begin
                w_rel_any = 1'b1;
                w_rel_idx = 2'(v);
                w_rel_age = r_age[v];
            end
            if (r_state[v] == c_HELD && (!w_held_any || r_age[v] > w_held_age)) begin
                w_held_any = 1'b1;
                w_held_idx = 2'(v);
                w_held_age = r_age[v];
            end
        end
`endif
        w_load  = 1'b0;
        w_alloc = 1'b0;
        w_steal = 1'b0;
        w_drop  = 1'b0;
        w_sel   = '0;
        if (w_on) begin
            if (w_hit) begin
                w_load = 1'b1;
                w_sel  = w_hit_idx;
            end else if (w_free_any) begin
                w_load  = 1'b1;
                w_alloc = 1'b1;
                w_sel   = w_free_idx;
            end else begin
`ifdef VOICE_STEAL_EN
                w_load  = 1'b1;
                w_alloc = 1'b1;
                w_steal = 1'b1;
                w_sel   = w_rel_any ? w_rel_idx : w_held_idx;
`else
                w_drop  = 1'b1;
`endif
            end
        end
    end

    always_comb begin
        w_ld   = '0;
        w_gon  = '0;
        w_goff = '0;
        w_busy = '0;
        for (int v = 0; v < c_NV; v++) begin
            w_nstate[v] = r_state[v];
            w_nage[v]   = r_age[v];
            w_ld[v]     = w_load && (w_sel == 2'(v));
            if (w_ld[v]) begin
                w_nstate[v] = c_HELD;
                w_nage[v]   = '0;
                w_gon[v]    = 1'b1;
            end else begin
                if (w_alloc && r_state[v] != c_FREE && r_age[v] != {AGE_W{1'b1}})
                    w_nage[v] = r_age[v] + AGE_W'(1);
                case (r_state[v])
                    c_HELD: begin
                        if (w_all || (w_off && r_note[v] == note_num)) begin
                            w_nstate[v] = c_REL;
                            w_goff[v]   = 1'b1;
                        end
                    end
                    c_REL: begin
                        if (env_idle[v])
                            w_nstate[v] = c_FREE;
                    end
                    default: w_nstate[v] = r_state[v];
                endcase
            end
            w_busy[v] = (w_nstate[v] != c_FREE);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_run      <= 1'b0;
            r_gate_on  <= '0;
            r_gate_off <= '0;
            r_busy     <= '0;
            r_steal    <= 1'b0;
            r_drop     <= 1'b0;
            for (int v = 0; v < c_NV; v++) begin
                r_state[v] <= c_FREE;
                r_note[v]  <= '0;
                r_vel[v]   <= '0;
                r_age[v]   <= '0;
            end
        end else begin
            r_run      <= 1'b1;
            r_gate_on  <= w_gon;
            r_gate_off <= w_goff;
            r_busy     <= w_busy;
            r_steal    <= w_steal;
            r_drop     <= w_drop;
            for (int v = 0; v < c_NV; v++) begin
                r_state[v] <= w_nstate[v];
                r_age[v]   <= w_nage[v];
                if (w_ld[v]) begin
                    r_note[v] <= note_num;
                    r_vel[v]  <= note_vel;
                end
            end
        end
    end

    for (genvar g = 0; g < c_NV; g++) begin : g_voice_out
        assign voice_note[7*g +: 7] = r_note[g];
        assign voice_vel[7*g +: 7]  = r_vel[g];
    end

    assign gate_on    = r_gate_on;
    assign gate_off   = r_gate_off;
    assign voice_busy = r_busy;
    assign steal      = r_steal;
    assign drop       = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_voice_alloc.sv
`default_nettype none
// ============================================================================
// Module      : tb_voice_alloc
// Description : Directed vector bench for voice_alloc (either VOICE_STEAL_EN build).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_voice_alloc;

`ifdef VOICE_STEAL_EN
    localparam bit c_STEAL = 1'b1;
`else
    localparam bit c_STEAL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  note_num = '0;
    logic [6:0]  note_vel = '0;
    logic        note_on = 1'b0;
    logic        note_off = 1'b0;
    logic        all_off = 1'b0;
    logic [3:0]  env_idle = '0;
    logic [27:0] voice_note, voice_vel;
    logic [3:0]  gate_on, gate_off, voice_busy;
    logic        steal, drop;

    int n_checks = 0;
    int n_errors = 0;

    voice_alloc #(.AGE_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .note_num   (note_num),
        .note_vel   (note_vel),
        .note_on    (note_on),
        .note_off   (note_off),
        .all_off    (all_off),
        .env_idle   (env_idle),
        .voice_note (voice_note),
        .voice_vel  (voice_vel),
        .gate_on    (gate_on),
        .gate_off   (gate_off),
        .voice_busy (voice_busy),
        .steal      (steal),
        .drop       (drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         on;
        bit         off;
        bit         all;
        logic [6:0] num;
        logic [6:0] vel;
        logic [3:0] idle;
        logic [3:0] e_gon;
        logic [3:0] e_goff;
        logic [3:0] e_busy;
        bit         e_steal;
        bit         e_drop;
        int         vidx;
        logic [6:0] e_note;
        logic [6:0] e_vel;
    } vec_t;

    vec_t tv[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs on the falling edge; return just after the rising edge.
    task automatic step(input bit on, input bit off, input bit all,
                        input logic [6:0] num, input logic [6:0] vel, input logic [3:0] idle);
        @(negedge clk);
        note_on  = on;
        note_off = off;
        all_off  = all;
        note_num = num;
        note_vel = vel;
        env_idle = idle;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        // on off all num vel idle | gon goff busy steal drop | vidx note vel
        tv.push_back('{1,0,0,60,100,4'b0000, 4'b0001,4'b0000,4'b0001,0,0, 0,60,100});
        tv.push_back('{1,0,0,62, 90,4'b0000, 4'b0010,4'b0000,4'b0011,0,0, 1,62, 90});
        tv.push_back('{1,0,0,64, 80,4'b0000, 4'b0100,4'b0000,4'b0111,0,0, 2,64, 80});
        tv.push_back('{1,0,0,65, 70,4'b0000, 4'b1000,4'b0000,4'b1111,0,0, 3,65, 70});
        tv.push_back('{0,1,0,62,  0,4'b0000, 4'b0000,4'b0010,4'b1111,0,0, 1,62, 90});
        tv.push_back('{0,0,0, 0,  0,4'b1111, 4'b0000,4'b0000,4'b1101,0,0, 1,62, 90});
        tv.push_back('{1,0,0,67, 60,4'b0000, 4'b0010,4'b0000,4'b1111,0,0, 1,67, 60});
        tv.push_back('{0,1,0,99,  0,4'b0000, 4'b0000,4'b0000,4'b1111,0,0, 0,60,100});
        tv.push_back('{0,1,0,64,  0,4'b0000, 4'b0000,4'b0100,4'b1111,0,0, 2,64, 80});
        tv.push_back('{1,0,0,70, 55,4'b0000, c_STEAL ? 4'b0100 : 4'b0000, 4'b0000, 4'b1111,
                       c_STEAL, !c_STEAL, 2, c_STEAL ? 7'd70 : 7'd64, c_STEAL ? 7'd55 : 7'd80});
        tv.push_back('{1,0,1,72, 33,4'b0000, 4'b0000, c_STEAL ? 4'b1111 : 4'b1011, 4'b1111,
                       0,0, 3,65,70});
        tv.push_back('{0,0,0, 0,  0,4'b1111, 4'b0000,4'b0000,4'b0000,0,0,
                       2, c_STEAL ? 7'd70 : 7'd64, c_STEAL ? 7'd55 : 7'd80});
        tv.push_back('{1,0,0,60,100,4'b0000, 4'b0001,4'b0000,4'b0001,0,0, 0,60,100});
        tv.push_back('{1,0,0,60, 50,4'b0000, 4'b0001,4'b0000,4'b0001,0,0, 0,60, 50});
        tv.push_back('{1,1,0,61, 40,4'b0000, 4'b0010,4'b0000,4'b0011,0,0, 1,61, 40});
        tv.push_back('{1,0,0,60,  0,4'b0000, 4'b0000,4'b0001,4'b0011,0,0, 0,60, 50});
        tv.push_back('{0,0,0, 0,  0,4'b0001, 4'b0000,4'b0000,4'b0010,0,0, 0,60, 50});

        // Reset asserted: outputs cleared.
        #2 rst = 1'b0;
        @(negedge clk);
        #2;
        chk("reset busy", 32'(voice_busy), 32'h0);
        chk("reset note", 32'(voice_note), 32'h0);
        chk("reset gates", 32'({gate_on, gate_off, steal, drop}), 32'h0);

        // Strobe coincident with reset release is ignored.
        @(negedge clk);
        rst      = 1'b1;
        note_on  = 1'b1;
        note_num = 7'd50;
        note_vel = 7'd50;
        @(posedge clk);
        #1;
        chk("release strobe busy", 32'(voice_busy), 32'h0);
        chk("release strobe gate_on", 32'(gate_on), 32'h0);
        step(0, 0, 0, 0, 0, 0);

        for (int i = 0; i < tv.size(); i++) begin
            step(tv[i].on, tv[i].off, tv[i].all, tv[i].num, tv[i].vel, tv[i].idle);
            chk($sformatf("v%0d gate_on", i),  32'(gate_on),    32'(tv[i].e_gon));
            chk($sformatf("v%0d gate_off", i), 32'(gate_off),   32'(tv[i].e_goff));
            chk($sformatf("v%0d busy", i),     32'(voice_busy), 32'(tv[i].e_busy));
            chk($sformatf("v%0d steal", i),    32'(steal),      32'(tv[i].e_steal));
            chk($sformatf("v%0d drop", i),     32'(drop),       32'(tv[i].e_drop));
            chk($sformatf("v%0d note", i), 32'(voice_note[7*tv[i].vidx +: 7]), 32'(tv[i].e_note));
            chk($sformatf("v%0d vel", i),  32'(voice_vel[7*tv[i].vidx +: 7]),  32'(tv[i].e_vel));
        end
        step(0, 0, 0, 0, 0, 0);

        // Asynchronous reset while voice 1 is held.
        @(negedge clk);
        #3 rst = 1'b0;
        #1;
        chk("async rst busy", 32'(voice_busy), 32'h0);
        chk("async rst note", 32'(voice_note), 32'h0);
        chk("async rst vel", 32'(voice_vel), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        step(0, 0, 0, 0, 0, 0);

        // Ages: v0 re-allocated late so wrapping would make v1 look oldest.
        step(1, 0, 0, 10, 5, 0);
        chk("post-reset alloc gate_on", 32'(gate_on), 32'h1);
        chk("post-reset alloc note", 32'(voice_note[6:0]), 32'd10);
        step(1, 0, 0, 11, 5, 0);
        step(1, 0, 0, 12, 5, 0);
        step(0, 1, 0, 10, 0, 0);
        step(0, 0, 0, 0, 0, 4'b0001);
        step(1, 0, 0, 13, 5, 0);
        chk("age setup gate_on", 32'(gate_on), 32'h1);
        chk("age setup busy", 32'(voice_busy), 32'h7);
        for (int i = 0; i < 70; i++) begin
            step(1, 0, 0, 20, 1, 0);
            chk($sformatf("age loop %0d gate_on", i), 32'(gate_on), 32'h8);
            if (i < 69) begin
                step(0, 1, 0, 20, 0, 0);
                step(0, 0, 0, 0, 0, 4'b1000);
            end
        end
        step(1, 0, 0, 30, 9, 0);
        chk("saturated gate_on", 32'(gate_on), c_STEAL ? 32'h1 : 32'h0);
        chk("saturated steal", 32'(steal), 32'(c_STEAL));
        chk("saturated drop", 32'(drop), 32'(!c_STEAL));
        chk("saturated v0 note", 32'(voice_note[6:0]), c_STEAL ? 32'd30 : 32'd13);
        chk("saturated v1 note", 32'(voice_note[13:7]), 32'd11);
        chk("saturated busy", 32'(voice_busy), 32'hF);
        step(0, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
